// File: rtl/mac_accum_pipe_core.sv
// mac_accum_pipe_core
//   Job-oriented, pipelined int8 multiply/accumulate core with LANES parallel
//   lanes. Each accepted step broadcasts one activation scalar against a
//   LANES-wide signed weight vector. The core accumulates the per-lane dot
//   products and then drains them one lane per word.
//
// Optional feature macro: MAC_ACC_SAT_EN
//   defined   - the accumulator add saturates, and sat_flag is a sticky per-job clamp flag
//   undefined - the accumulator add wraps, and sat_flag is tied low
//
// Ports
//   CLK, RESETn        clock (rising edge), asynchronous active-low reset
//   start              job start pulse, honoured only in IDLE
//   cfg_k_len          number of steps in the job (latched on start)
//   cfg_act_signed     activation signedness (latched on start)
//   acc_load_en        on start: 1 = preload acc_load_data, 0 = clear
//   acc_load_data      preload values, lane i at [i*ACC_W +: ACC_W]
//   abort              synchronous job abort, highest priority
//   in_valid/in_ready  step handshake, carrying act_k and w_vec
//   act_k, w_vec       activation scalar and signed weights (lane i at [i*DATA_W +: DATA_W])
//   out_valid/out_ready drain handshake
//   out_data, out_lane accumulator value and its lane index
//   busy               high whenever the core is not IDLE
//   done               one-cycle pulse after the last lane is accepted
//   sat_flag           sticky saturation indicator for the current job
module mac_accum_pipe_core #(
    parameter int LANES  = 32,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int KLEN_W = 16,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    start,
    input  logic [KLEN_W-1:0]       cfg_k_len,
    input  logic                    cfg_act_signed,
    input  logic                    acc_load_en,
    input  logic [LANES*ACC_W-1:0]  acc_load_data,
    input  logic                    abort,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       act_k,
    input  logic [LANES*DATA_W-1:0] w_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [LANE_W-1:0]       out_lane,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag
);

    localparam int PW = 2*DATA_W + 2;   // signed product width

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FLUSH, ST_DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [KLEN_W-1:0]   k_len_reg;
    logic [KLEN_W-1:0]   step_cnt_reg, step_cnt_next;
    logic [LANE_W-1:0]   lane_reg, lane_next;
    logic                act_signed_reg;
    logic                v1_reg;        // stage 1: products registered
    logic                v2_reg;        // stage 2: addends ready for the accumulator
    logic                done_reg;
    logic [LANES*ACC_W-1:0] acc_flat;

    logic start_ok, step_acc, drain_acc, last_lane;

    // abort masks every other event in the same cycle
    assign start_ok  = (state_reg == ST_IDLE) && start && !abort;
    assign in_ready  = (state_reg == ST_ACCUM);
    assign step_acc  = in_ready && in_valid && !abort;
    assign drain_acc = (state_reg == ST_DRAIN) && out_ready && !abort;
    assign last_lane = (lane_reg == LANE_W'(LANES - 1));

    assign out_valid = (state_reg == ST_DRAIN);
    assign out_data  = out_valid ? acc_flat[lane_reg*ACC_W +: ACC_W] : '0;
    assign out_lane  = out_valid ? lane_reg : '0;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;

    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg;
        lane_next     = lane_reg;
        if (abort) begin
            state_next = ST_IDLE;
            lane_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        step_cnt_next = '0;
                        state_next    = (cfg_k_len == '0) ? ST_FLUSH : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        step_cnt_next = step_cnt_reg + KLEN_W'(1);
                        if (step_cnt_next == k_len_reg)
                            state_next = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // No steps enter during FLUSH. Once stage 1 is empty, the
                    // stage-2 addend (if any) lands in the accumulator on the
                    // same edge that enters DRAIN. Both valids are then clear.
                    if (!v1_reg) begin
                        state_next = ST_DRAIN;
                        lane_next  = '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (last_lane) begin
                            state_next = ST_IDLE;
                            lane_next  = '0;
                        end else begin
                            lane_next = lane_reg + LANE_W'(1);
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg      <= ST_IDLE;
            step_cnt_reg   <= '0;
            lane_reg       <= '0;
            k_len_reg      <= '0;
            act_signed_reg <= 1'b0;
            v1_reg         <= 1'b0;
            v2_reg         <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            step_cnt_reg <= step_cnt_next;
            lane_reg     <= lane_next;
            if (start_ok) begin
                k_len_reg      <= cfg_k_len;
                act_signed_reg <= cfg_act_signed;
            end
            v1_reg   <= step_acc;
            v2_reg   <= v1_reg && !abort;
            done_reg <= drain_acc && last_lane;
        end
    end

`ifdef MAC_ACC_SAT_EN
    logic [LANES-1:0] clamp_vec;
    logic             sat_reg;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            sat_reg <= 1'b0;
        else if (start_ok)
            sat_reg <= 1'b0;
        else if (v2_reg && !abort && (|clamp_vec))
            sat_reg <= 1'b1;
    end
    assign sat_flag = sat_reg;
`else
    assign sat_flag = 1'b0;
`endif

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [DATA_W:0]  act_ext, w_ext;
        logic signed [PW-1:0]    prod_comb, prod_reg;
        logic signed [ACC_W-1:0] addend_reg, acc_reg, sum_comb;

        // The activation MSB extends only when the job is in signed mode.
        // Weights are always signed.
        assign act_ext   = {act_signed_reg & act_k[DATA_W-1], act_k};
        assign w_ext     = {w_vec[gi*DATA_W + DATA_W-1], w_vec[gi*DATA_W +: DATA_W]};
        assign prod_comb = PW'(act_ext) * PW'(w_ext);

`ifdef MAC_ACC_SAT_EN
        logic [ACC_W:0] wide_sum;
        logic           ovf;
        // One guard bit: overflow shows up as a mismatch between the top two bits
        assign wide_sum = {acc_reg[ACC_W-1], acc_reg} + {addend_reg[ACC_W-1], addend_reg};
        assign ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
        assign sum_comb = !ovf ? wide_sum[ACC_W-1:0] :
                          (wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}});
        assign clamp_vec[gi] = ovf;
`else
        assign sum_comb = acc_reg + addend_reg;
`endif

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                prod_reg   <= '0;
                addend_reg <= '0;
                acc_reg    <= '0;
            end else begin
                if (step_acc)
                    prod_reg <= prod_comb;
                if (v1_reg)
                    addend_reg <= ACC_W'(prod_reg);
                if (start_ok)
                    acc_reg <= acc_load_en ? acc_load_data[gi*ACC_W +: ACC_W] : '0;
                else if (v2_reg && !abort)
                    acc_reg <= sum_comb;
            end
        end

        assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;
    end

endmodule

// File: tb/tb_mac_accum_pipe_core.sv
module tb_mac_accum_pipe_core;
    localparam int LANES = 4, DATA_W = 8, ACC_W = 32, KLEN_W = 16;
`ifdef MAC_ACC_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic CLK, RESETn, start, cfg_act_signed, acc_load_en, abort;
    logic in_valid, in_ready, out_valid, out_ready, busy, done, sat_flag;
    logic [KLEN_W-1:0]       cfg_k_len;
    logic [LANES*ACC_W-1:0]  acc_load_data;
    logic [DATA_W-1:0]       act_k;
    logic [LANES*DATA_W-1:0] w_vec;
    logic [ACC_W-1:0]        out_data;
    logic [1:0]              out_lane;

    mac_accum_pipe_core #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
        .CLK(CLK), .RESETn(RESETn), .start(start), .cfg_k_len(cfg_k_len),
        .cfg_act_signed(cfg_act_signed), .acc_load_en(acc_load_en),
        .acc_load_data(acc_load_data), .abort(abort), .in_valid(in_valid),
        .in_ready(in_ready), .act_k(act_k), .w_vec(w_vec), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_lane(out_lane),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef logic [3:0][31:0] avec_t;
    typedef struct packed {
        logic [15:0]      k_len;
        logic             act_signed;
        logic             load_en;
        avec_t            load;
        logic [3:0][7:0]  act;    // per step
        logic [3:0][31:0] w;      // per step, 4 lanes x 8 bits
        avec_t            exp;
        logic             exp_sat;
    } vec_t;

    vec_t vecs[7];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic avec_t a32(input int a, input int b, input int c, input int d);
        avec_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic logic [31:0] w4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [3:0][7:0] a8(input int a, input int b);
        logic [3:0][7:0] r;
        r = '0; r[0] = a[7:0]; r[1] = b[7:0];
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] k, input logic sgn, input logic ld, input avec_t ldd);
        cfg_k_len = k; cfg_act_signed = sgn; acc_load_en = ld; acc_load_data = ldd;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0; acc_load_en = 1'b0;
    endtask

    // Start a job, stream its steps back to back, time FLUSH, drain with no stalls
    task automatic run_vec(input vec_t v, input int idx);
        int fl;
        do_start(v.k_len, v.act_signed, v.load_en, v.load);
        chk("busy_after_start", busy, 1);
        for (int s = 0; s < int'(v.k_len); s++) begin
            in_valid = 1'b1; act_k = v.act[s]; w_vec = v.w[s];
            chk("in_ready_accum", in_ready, 1);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        chk("flush_entry_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        fl = 1;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(negedge CLK);
            if (!out_valid) fl++;
        end
        chk("drain_reached", out_valid, 1);
        chk("flush_len", fl, (v.k_len == 0) ? 1 : 2);
        out_ready = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            $display("job %0d lane %0d data %0d", idx, out_lane, $signed(out_data));
            chk("drain_valid", out_valid, 1);
            chk("drain_lane", out_lane, l);
            chk("drain_data", longint'($signed(out_data)), longint'($signed(v.exp[l])));
            chk("drain_sat_flag", sat_flag, v.exp_sat);
            chk("done_early", done, 0);
            @(negedge CLK);
        end
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("out_valid_end", out_valid, 0);
        @(negedge CLK);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r_act[16];
        logic [31:0] r_w[16];
        longint      r_exp[4];
        logic        r_sgn, hs, seen, prev_stall;
        logic [31:0] prev_data;
        logic [1:0]  prev_lane;
        int          idx, cnt, guard, a, w;

        RESETn = 1'b0; start = 0; cfg_k_len = 0; cfg_act_signed = 0; acc_load_en = 0;
        acc_load_data = '0; abort = 0; in_valid = 0; act_k = 0; w_vec = 0; out_ready = 0;

        for (int i = 0; i < 7; i++) vecs[i] = '0;
        vecs[0].k_len = 3; vecs[0].act_signed = 1; vecs[0].act = '0;
        vecs[0].act[0] = 8'd2; vecs[0].act[1] = 8'hFF; vecs[0].act[2] = 8'd5;
        vecs[0].w[0] = w4(1, -1, 3, 0); vecs[0].w[1] = w4(4, 4, 4, 4); vecs[0].w[2] = w4(0, 0, -2, 127);
        vecs[0].exp = a32(-2, -6, -8, 631);

        vecs[1].k_len = 1; vecs[1].act_signed = 0; vecs[1].load_en = 1;
        vecs[1].load = a32(100, 0, -50, 7); vecs[1].act = a8(255, 0);
        vecs[1].w[0] = w4(-1, 1, 2, 0); vecs[1].exp = a32(-155, 255, 460, 7);

        vecs[2].k_len = 1; vecs[2].act_signed = 1; vecs[2].load_en = 1;
        vecs[2].load = a32(2147483392, -2147483548, 0, 2147467518); vecs[2].act = a8(127, 0);
        vecs[2].w[0] = w4(127, -127, 127, 127);
        vecs[2].exp = SAT_ON ? a32(2147483647, -2147483647 - 1, 16129, 2147483647)
                             : a32(-2147467775, 2147467619, 16129, 2147483647);
        vecs[2].exp_sat = SAT_ON;

        vecs[3].k_len = 0; vecs[3].load_en = 1; vecs[3].load = a32(5, 6, 7, 8);
        vecs[3].exp = a32(5, 6, 7, 8);

        vecs[4].k_len = 2; vecs[4].act_signed = 1; vecs[4].act = a8(-128, 127);
        vecs[4].w[0] = w4(-128, 127, -128, 1); vecs[4].w[1] = w4(127, -128, 0, -1);
        vecs[4].exp = a32(32513, -32512, 16384, -255);

        vecs[5].k_len = 2; vecs[5].act_signed = 0; vecs[5].act = a8(128, 200);
        vecs[5].w[0] = w4(-128, 1, 0, 0); vecs[5].w[1] = w4(0, 0, -1, 127);
        vecs[5].exp = a32(-16384, 128, -200, 25400);

        vecs[6].k_len = 1; vecs[6].act_signed = 1; vecs[6].act = a8(1, 0);
        vecs[6].w[0] = w4(1, 1, 1, 1); vecs[6].exp = a32(1, 1, 1, 1);

        // Reset state
        #12;
        chk("rst_busy", busy, 0);         chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0); chk("rst_done", done, 0);
        chk("rst_sat_flag", sat_flag, 0); chk("rst_out_data", out_data, 0);
        chk("rst_out_lane", out_lane, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Random in_valid gaps and out_ready stalls on a 16-step job
        r_sgn = 1'($urandom_range(0, 1));
        for (int l = 0; l < 4; l++) r_exp[l] = 0;
        for (int s = 0; s < 16; s++) begin
            r_act[s] = 8'($urandom_range(0, 255));
            r_w[s]   = $urandom;
            a = r_sgn ? int'($signed(r_act[s])) : int'(r_act[s]);
            for (int l = 0; l < 4; l++) begin
                w = int'($signed(r_w[s][l*8 +: 8]));
                r_exp[l] += longint'(a * w);
            end
        end
        do_start(16, r_sgn, 1'b0, '0);
        idx = 0; guard = 0;
        while (idx < 16 && guard < 400) begin
            in_valid = ($urandom_range(0, 2) != 0);
            act_k = r_act[idx]; w_vec = r_w[idx];
            hs = in_valid && in_ready;
            @(negedge CLK);
            guard++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        chk("rand_steps_accepted", idx, 16);
        chk("rand_in_ready_after_last", in_ready, 0);
        cnt = 0; guard = 0; seen = 0; prev_stall = 0; prev_data = '0; prev_lane = '0;
        while (cnt < 4 && guard < 200) begin
            if (!seen && out_valid) begin
                out_ready = 1'b0; seen = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (out_valid) begin
                if (prev_stall) begin
                    chk("stall_data_stable", out_data, prev_data);
                    chk("stall_lane_stable", out_lane, prev_lane);
                end
                if (out_ready) begin
                    $display("job rand lane %0d data %0d", out_lane, $signed(out_data));
                    chk("rand_lane", out_lane, cnt);
                    chk("rand_data", longint'($signed(out_data)), r_exp[cnt]);
                    cnt++;
                end
                prev_stall = !out_ready; prev_data = out_data; prev_lane = out_lane;
            end else begin
                prev_stall = 1'b0;
            end
            @(negedge CLK);
            guard++;
        end
        out_ready = 1'b0;
        chk("rand_drained", cnt, 4);
        chk("rand_done", done, 1);
        @(negedge CLK);

        // start together with abort in IDLE: abort wins
        cfg_k_len = 1; start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle_busy", busy, 0);
        chk("start_abort_idle_in_ready", in_ready, 0);

        // abort one cycle after the 2nd accept of an 8-step job; start mid-job ignored
        do_start(8, 1'b1, 1'b0, '0);
        in_valid = 1'b1; act_k = 8'd3; w_vec = w4(1, 2, 3, 4);
        @(negedge CLK);
        start = 1'b1; cfg_k_len = 1;
        @(negedge CLK);
        start = 1'b0; in_valid = 1'b0;
        chk("start_ignored_in_accum", in_ready, 1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_no_done", done, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            chk("abort_stays_idle", busy, 0);
            chk("abort_no_done_later", done, 0);
        end
        run_vec(vecs[6], 6);

        // Asynchronous reset in the middle of DRAIN
        do_start(0, 1'b0, 1'b1, a32(5, 6, 7, 8));
        for (int c = 0; c < 10 && !out_valid; c++) @(negedge CLK);
        chk("rst_test_drain_reached", out_valid, 1);
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk("rst_test_lane1", out_lane, 1);
        chk("rst_test_data1", out_data, 6);
        #2 RESETn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_lane", out_lane, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
